i2c_master: RTL
===============

Name: i2c_master

Overview:
- Single-byte I2C initiator, the controller end of the bus our I2C responders sit on.
- On a command pulse it performs one transaction: START, 7-bit address + R/W, address ACK check, one data byte written or read, then STOP.
- It generates SCL from the system clock and drives SCL/SDA as open-drain enables; external pads or bench pull-ups resolve the bus.
- It sits between the CPU register interface and the bus pads.

Parameters:
- CLK_DIV, 'd125, system clocks per SCL quarter-period. Must be at least 2. One SCL bit period is 4*CLK_DIV clocks.

Ports:
- clk  input  1  system clock; every flop samples on its rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle command pulse; sampled only in IDLE.
- rw  input  1  0 = write wdata, 1 = read into rdata; latched when start is accepted.
- addr  input  7  target address; latched when start is accepted.
- wdata  input  8  write byte; latched when start is accepted.
- rdata  output  8  byte received on a read; holds its value until the next read completes.
- busy  output  1  high from the cycle after an accepted start until the cycle done asserts.
- done  output  1  one-cycle pulse at the end of STOP.
- ack_err  output  1  set with done if any ACK slot read high; cleared on the next accepted start.
- scl_in  input  1  resolved SCL line level.
- sda_in  input  1  resolved SDA line level.
- scl_oe  output  1  1 = pull SCL low, 0 = release.
- sda_oe  output  1  1 = pull SDA low, 0 = release.

Behaviour:
- Reset values: scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0, rdata=8'h00. Reset mid-transaction releases both lines in the next cycle and returns to IDLE with no STOP generated.
- Quarter tick: a divider counts 0..CLK_DIV-1 and raises an internal tick on wrap. The divider is held at 0 while in IDLE. A phase counter q cycles 0..3 on ticks.
- Bit timing, per bit:
  - q0: SCL low; SDA updated.
  - q1: SCL released.
  - q2: SCL high; sda_in sampled on the tick ending q2.
  - q3: SCL pulled low.
- States and transitions:
  - IDLE: both lines released. An accepted start latches {addr, rw} into an 8-bit shift register, latches wdata, clears ack_err, and moves to START.
  - START: SCL released. sda_oe=1 for 2 quarters (SDA falls while SCL is high). Then SCL is pulled low; move to ADDR with bitcount=0.
  - ADDR: shift the 8 bits MSB first; sda_oe = ~bit. After bit 7, go to ADDR_ACK.
  - ADDR_ACK: release SDA for one bit and sample it.
    - Sample 1: set ack_err and go to STOP.
    - Sample 0: go to WRITE if rw=0, or READ if rw=1.
  - WRITE: 8 bits of wdata, MSB first, then WRITE_ACK. WRITE_ACK samples like ADDR_ACK (a 1 sets ack_err) and always goes to STOP.
  - READ: SDA released; 8 bits shifted in MSB first. Then READ_ACK.
  - READ_ACK: drive NACK (SDA released) for one bit. Load rdata from the shift register, then go to STOP.
  - STOP: q0 sda_oe=1; q1 SCL released; q3 SDA released (SDA rises while SCL is high). Then done pulses for 1 cycle and the state returns to IDLE.
- bitcount is 4 bits, cleared on entry to each byte state; a byte ends on the q3 tick when bitcount==7.
- A start pulse while busy=1 is ignored and has no effect on the transaction in progress.
- Latency: a write transaction is 2 + 9 + 9 + 4 quarters... expressed in SCL bits it is START (1 bit) + 9 + 9 + STOP (1 bit) = 20*4*CLK_DIV clocks, ±1 cycle, from start to done. A read has the same length. An address NACK takes 11*4*CLK_DIV clocks.
- SDA changes only while SCL is low, except in the START and STOP phases.

Optional Feature:
- CLOCK_STRETCH_EN
  - Defined: during q1 or q2, if scl_in=0 while scl_oe=0, the divider and the phase counter freeze. Counting resumes on the cycle after scl_in reads 1, which honours responder clock stretching.
  - Undefined: scl_in is ignored and timing is purely divider-driven.

Test Plan:
- Write, CLK_DIV=4, addr=7'h51, rw=0, wdata=8'hA5, bench responder ACKs both slots -> SDA bits 1010_0010, ACK, 1010_0101, ACK, then STOP. done pulses once with ack_err=0, 320±1 clocks after start.
- Read, addr=7'h51, rw=1, responder ACKs and returns 8'hCA -> rdata=8'hCA at done, master leaves SDA released in the 9th bit (NACK), ack_err=0.
- Wrong address 7'h22 with no responder (SDA stays high) -> ack_err=1, STOP immediately after the address byte, done after 176±1 clocks, no data byte on the bus.
- start pulsed again at cycle 50 of a transaction -> ignored; bus waveform identical to the single-start case.
- rst asserted during the WRITE byte -> next cycle scl_oe=0, sda_oe=0, busy=0. A new transaction then completes normally.
- CLOCK_STRETCH_EN, responder holds SCL low for 37 extra clocks during address bit 3 -> done is delayed by exactly 37 clocks and no bit is corrupted.

Source files
------------

// File: rtl/i2c_master.sv
`default_nettype none
// i2c_master: single-byte I2C controller (START, addr+R/W, ACK, one data byte, STOP). Rev 1.0
// Define CLOCK_STRETCH_EN to honour responder SCL stretching during the SCL-high quarters.
module i2c_master #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] c_DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START     = 4'd1,
    S_ADDR      = 4'd2,
    S_ADDR_ACK  = 4'd3,
    S_WRITE     = 4'd4,
    S_WRITE_ACK = 4'd5,
    S_READ      = 4'd6,
    S_READ_ACK  = 4'd7,
    S_STOP      = 4'd8
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_q;
  logic [3:0]       r_bitcnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_wdata;
  logic [7:0]       r_rdata;
  logic             r_rw;
  logic             r_nack;
  logic             r_done;
  logic             r_ack_err;

  logic             w_stall;
  logic             w_tick;
  logic             w_q2_tick;
  logic             w_q3_tick;
  logic             w_byte_end;
  logic             w_data_scl;
  logic             w_scl_oe;
  logic             w_sda_oe;

`ifdef CLOCK_STRETCH_EN
  // A responder holding SCL low while we have released it freezes all timing.
  assign w_stall = (r_state != S_IDLE) && ((r_q == 2'd1) || (r_q == 2'd2)) &&
                   !w_scl_oe && !scl_in;
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_in;
  assign w_stall      = 1'b0;
`endif

  assign w_tick     = (r_state != S_IDLE) && !w_stall && (r_div == c_DIV_MAX);
  assign w_q2_tick  = w_tick && (r_q == 2'd2);
  assign w_q3_tick  = w_tick && (r_q == 2'd3);
  assign w_byte_end = w_q3_tick && (r_bitcnt == 4'd7);
  assign w_data_scl = (r_q == 2'd0) || (r_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (start) w_state_nxt = S_START;
      S_START:     if (w_q3_tick) w_state_nxt = S_ADDR;
      S_ADDR:      if (w_byte_end) w_state_nxt = S_ADDR_ACK;
      S_ADDR_ACK: begin
        if (w_q3_tick) begin
          if (r_nack) w_state_nxt = S_STOP;
          else if (r_rw) w_state_nxt = S_READ;
          else w_state_nxt = S_WRITE;
        end
      end
      S_WRITE:     if (w_byte_end) w_state_nxt = S_WRITE_ACK;
      S_WRITE_ACK: if (w_q3_tick) w_state_nxt = S_STOP;
      S_READ:      if (w_byte_end) w_state_nxt = S_READ_ACK;
      S_READ_ACK:  if (w_q3_tick) w_state_nxt = S_STOP;
      S_STOP:      if (w_q3_tick) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_scl_oe = 1'b0;
    w_sda_oe = 1'b0;
    case (r_state)
      S_START: begin
        w_sda_oe = 1'b1;
        w_scl_oe = r_q[1];
      end
      S_ADDR, S_WRITE: begin
        w_scl_oe = w_data_scl;
        w_sda_oe = ~r_shift[7];
      end
      S_ADDR_ACK, S_WRITE_ACK, S_READ, S_READ_ACK: begin
        w_scl_oe = w_data_scl;
      end
      S_STOP: begin
        // SDA low first, SCL released in q1, SDA released in q3 -> STOP edge.
        w_scl_oe = (r_q == 2'd0);
        w_sda_oe = (r_q != 2'd3);
      end
      default: begin
        w_scl_oe = 1'b0;
        w_sda_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_q       <= 2'd0;
      r_bitcnt  <= 4'd0;
      r_shift   <= 8'h00;
      r_wdata   <= 8'h00;
      r_rdata   <= 8'h00;
      r_rw      <= 1'b0;
      r_nack    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_div <= '0;
        r_q   <= 2'd0;
        if (start) begin
          r_shift   <= {addr, rw};
          r_wdata   <= wdata;
          r_rw      <= rw;
          r_nack    <= 1'b0;
          r_ack_err <= 1'b0;
          r_bitcnt  <= 4'd0;
        end
      end else begin
        if (!w_stall) begin
          r_div <= w_tick ? '0 : r_div + 1'b1;
        end
        if (w_tick) begin
          r_q <= r_q + 2'd1;
        end
        // Any state change restarts the bit count for the next byte.
        if (w_q3_tick) begin
          r_bitcnt <= (w_state_nxt != r_state) ? 4'd0 : r_bitcnt + 4'd1;
        end
        case (r_state)
          S_ADDR, S_WRITE: begin
            if (w_q3_tick) r_shift <= {r_shift[6:0], 1'b0};
          end
          S_ADDR_ACK, S_WRITE_ACK: begin
            if (w_q2_tick && sda_in) r_nack <= 1'b1;
            if (w_q3_tick && (w_state_nxt == S_WRITE)) r_shift <= r_wdata;
          end
          S_READ: begin
            if (w_q2_tick) r_shift <= {r_shift[6:0], sda_in};
          end
          S_READ_ACK: begin
            if (w_q3_tick) r_rdata <= r_shift;
          end
          S_STOP: begin
            if (w_q3_tick) begin
              r_done    <= 1'b1;
              r_ack_err <= r_nack;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign scl_oe  = w_scl_oe;
  assign sda_oe  = w_sda_oe;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign ack_err = r_ack_err;
  assign rdata   = r_rdata;

endmodule
`default_nettype wire
